// File: rtl/l2_arb_pkg.sv
// Shared types and default widths for the L1-to-L2 port arbiter.
package l2_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } arb_state_t;

  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } req_id_t;

  localparam int unsigned ADDR_W_DEF = 32;
  localparam int unsigned LINE_W_DEF = 256;

endpackage

// File: rtl/l2_port_arbiter.sv
// Round-robin arbiter sharing one L2 port between the L1 I-cache and D-cache miss paths.
// The winner's address, write line and operation are held in registers for the whole transaction.
module l2_port_arbiter
  import l2_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned LINE_W = LINE_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_resp,
  output logic [LINE_W-1:0] i_rdata,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic              d_resp,
  output logic [LINE_W-1:0] d_rdata,
  output logic              l2_read,
  output logic              l2_write,
  output logic [ADDR_W-1:0] l2_addr,
  output logic [LINE_W-1:0] l2_wdata,
  input  logic              l2_resp,
  input  logic [LINE_W-1:0] l2_rdata
);

  arb_state_t        r_state;
  arb_state_t        w_next_state;
  req_id_t           r_last_grant;
  req_id_t           w_winner;
  logic              r_op_write;
  logic [ADDR_W-1:0] r_addr;
  logic [LINE_W-1:0] r_wdata;
  logic              w_d_req;
  logic              w_any_req;

  assign w_d_req   = d_read | d_write;
  assign w_any_req = i_read | w_d_req;

  // Round-robin: on contention the requester not served last time wins.
  always_comb begin
    if (i_read && w_d_req) w_winner = (r_last_grant == REQ_I) ? REQ_D : REQ_I;
    else if (i_read)       w_winner = REQ_I;
    else                   w_winner = REQ_D;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (w_any_req) w_next_state = (w_winner == REQ_I) ? GRANT_I : GRANT_D;
      end
      GRANT_I, GRANT_D: begin
        if (l2_resp) w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_last_grant <= REQ_I;
      r_op_write   <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
    end else begin
      r_state <= w_next_state;
      if (r_state == IDLE && w_any_req) begin
        r_last_grant <= w_winner;
        r_op_write   <= (w_winner == REQ_D) && d_write;
        r_addr       <= (w_winner == REQ_D) ? d_addr : i_addr;
        r_wdata      <= (w_winner == REQ_D) ? d_wdata : '0;
      end
    end
  end

  always_comb begin
    l2_read  = 1'b0;
    l2_write = 1'b0;
    i_resp   = 1'b0;
    d_resp   = 1'b0;
    if (r_state == GRANT_I || r_state == GRANT_D) begin
      l2_read  = ~r_op_write;
      l2_write = r_op_write;
    end
    if (r_state == GRANT_I) i_resp = l2_resp;
    if (r_state == GRANT_D) d_resp = l2_resp;
  end

  assign l2_addr  = r_addr;
  assign l2_wdata = r_wdata;
  assign i_rdata  = l2_rdata;
  assign d_rdata  = l2_rdata;

endmodule

// File: tb/tb_l2_port_arbiter.sv
// Directed and randomized checks of l2_port_arbiter against a transaction-level reference model.
module tb_l2_port_arbiter;
  localparam int unsigned AW = 32;
  localparam int unsigned LW = 256;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_read;
  logic [AW-1:0] i_addr;
  logic          i_resp;
  logic [LW-1:0] i_rdata;
  logic          d_read;
  logic          d_write;
  logic [AW-1:0] d_addr;
  logic [LW-1:0] d_wdata;
  logic          d_resp;
  logic [LW-1:0] d_rdata;
  logic          l2_read;
  logic          l2_write;
  logic [AW-1:0] l2_addr;
  logic [LW-1:0] l2_wdata;
  logic          l2_resp;
  logic [LW-1:0] l2_rdata;

  l2_port_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_addr(i_addr), .i_resp(i_resp), .i_rdata(i_rdata),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_resp(d_resp), .d_rdata(d_rdata),
    .l2_read(l2_read), .l2_write(l2_write), .l2_addr(l2_addr), .l2_wdata(l2_wdata),
    .l2_resp(l2_resp), .l2_rdata(l2_rdata)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: one outstanding transaction record plus the last winner (1 = D-cache).
  logic          m_busy;
  logic          m_who_d;
  logic          m_last_d;
  logic          m_write;
  logic [AW-1:0] m_addr;
  logic [LW-1:0] m_wdata;
  logic          m_after_rst;
  logic          order_q[$];
  logic          dut_i_resp;
  logic          dut_d_resp;

  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [LW-1:0] rnd_line();
    logic [LW-1:0] v;
    for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom();
    return v;
  endfunction

  task automatic model_reset();
    m_busy      = 1'b0;
    m_who_d     = 1'b0;
    m_last_d    = 1'b0;
    m_write     = 1'b0;
    m_addr      = '0;
    m_wdata     = '0;
    m_after_rst = 1'b1;
  endtask

  // Check outputs mid-cycle, advance the model by one clock, return just after the edge.
  task automatic step();
    logic d_req;
    @(negedge clk);
    chk("l2_read", l2_read, m_busy && !m_write);
    chk("l2_write", l2_write, m_busy && m_write);
    if (m_busy || m_after_rst) begin
      chk("l2_addr", l2_addr, m_addr);
      chk("l2_wdata", l2_wdata, m_wdata);
    end
    chk("i_resp", i_resp, m_busy && !m_who_d && l2_resp);
    chk("d_resp", d_resp, m_busy && m_who_d && l2_resp);
    chk("i_rdata", i_rdata, l2_rdata);
    chk("d_rdata", d_rdata, l2_rdata);
    dut_i_resp  = i_resp;
    dut_d_resp  = d_resp;
    m_after_rst = 1'b0;
    d_req = d_read | d_write;
    if (rst) begin
      model_reset();
    end else if (m_busy) begin
      if (l2_resp) begin
        m_busy = 1'b0;
        order_q.push_back(m_who_d);
      end
    end else if (i_read || d_req) begin
      m_who_d  = (i_read && d_req) ? !m_last_d : d_req;
      m_last_d = m_who_d;
      m_busy   = 1'b1;
      m_addr   = m_who_d ? d_addr : i_addr;
      m_wdata  = m_who_d ? d_wdata : '0;
      m_write  = m_who_d && d_write;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  // Wait lat cycles, pulse l2_resp with a fresh line, optionally drop the served request.
  task automatic serve(input int lat, input bit drop);
    repeat (lat) step();
    l2_rdata = rnd_line();
    l2_resp  = 1'b1;
    step();
    l2_resp = 1'b0;
    if (drop && dut_i_resp) i_read = 1'b0;
    if (drop && dut_d_resp) begin d_read = 1'b0; d_write = 1'b0; end
  endtask

  initial begin
    rst = 1'b1; i_read = 0; i_addr = '0; d_read = 0; d_write = 0; d_addr = '0;
    d_wdata = '0; l2_resp = 0; l2_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    rst = 1'b0;
    step();

    // 1: lone I-cache read, L2 answers 5 cycles later.
    i_read = 1'b1; i_addr = 32'h0000_1000;
    step();
    chk("t1_l2_read", l2_read, 1'b1);
    chk("t1_l2_addr", l2_addr, 32'h0000_1000);
    serve(4, 1'b1);
    chk("t1_i_resp", dut_i_resp, 1'b1);
    chk("t1_d_resp", dut_d_resp, 1'b0);
    step();

    // 2: D-cache writeback.
    d_write = 1'b1; d_addr = 32'h0000_2000; d_wdata = {32{8'hA5}};
    step();
    chk("t2_l2_write", l2_write, 1'b1);
    chk("t2_l2_wdata", l2_wdata, {32{8'hA5}});
    serve(3, 1'b1);
    chk("t2_d_resp", dut_d_resp, 1'b1);
    chk("t2_i_resp", dut_i_resp, 1'b0);
    step();

    // 3: simultaneous from reset, D wins first.
    do_reset();
    order_q.delete();
    i_read = 1'b1; i_addr = 32'h0000_3000; d_read = 1'b1; d_addr = 32'h0000_4000;
    step();
    serve(2, 1'b1);
    step();
    serve(2, 1'b1);
    chk("t3_count", order_q.size(), 2);
    if (order_q.size() == 2) begin
      chk("t3_first_d", order_q[0], 1'b1);
      chk("t3_second_i", order_q[1], 1'b0);
    end
    step();

    // 4: both held continuously -> D,I,D,I.
    do_reset();
    order_q.delete();
    i_read = 1'b1; d_read = 1'b1;
    repeat (4) begin
      step();
      serve(1, 1'b0);
    end
    i_read = 1'b0; d_read = 1'b0;
    chk("t4_count", order_q.size(), 4);
    if (order_q.size() == 4)
      for (int k = 0; k < 4; k++) chk($sformatf("t4_order%0d", k), order_q[k], (k % 2) == 0);
    step();

    // 5: spurious l2_resp in IDLE, then reset mid-GRANT_D with a response in flight.
    l2_resp = 1'b1; l2_rdata = rnd_line();
    repeat (2) step();
    l2_resp = 1'b0;
    d_read = 1'b1; d_addr = 32'h0000_5000;
    repeat (2) step();
    rst = 1'b1; l2_resp = 1'b1;
    step();
    rst = 1'b0; l2_resp = 1'b0; d_read = 1'b0; l2_rdata = '0;
    chk("t5_l2_read", l2_read, 1'b0);
    chk("t5_d_resp", d_resp, 1'b0);
    chk("t5_l2_addr", l2_addr, '0);
    step();

    // 6: address and request changes mid-grant are ignored.
    d_read = 1'b1; d_addr = 32'h0000_6000;
    step();
    d_addr = 32'h0000_7000; d_read = 1'b0; i_read = 1'b1; i_addr = 32'h0000_8000;
    repeat (3) step();
    chk("t6_l2_addr", l2_addr, 32'h0000_6000);
    serve(0, 1'b1);
    chk("t6_d_resp", dut_d_resp, 1'b1);
    i_read = 1'b0;
    repeat (3) step();

    // Randomized traffic, including drops, address churn, spurious responses and resets.
    for (int n = 0; n < 600; n++) begin
      if (!i_read && $urandom_range(3) == 0) begin
        i_read = 1'b1; i_addr = $urandom() & 32'hFFFF_FFE0;
      end
      if (!d_read && !d_write && $urandom_range(3) == 0) begin
        if ($urandom_range(1) == 0) d_read = 1'b1; else d_write = 1'b1;
        d_addr = $urandom() & 32'hFFFF_FFE0; d_wdata = rnd_line();
      end
      if ($urandom_range(15) == 0) i_addr = $urandom() & 32'hFFFF_FFE0;
      if ($urandom_range(15) == 0) d_addr = $urandom() & 32'hFFFF_FFE0;
      if ($urandom_range(31) == 0) i_read = 1'b0;
      l2_resp  = ($urandom_range(2) == 0);
      l2_rdata = rnd_line();
      rst      = ($urandom_range(96) == 0);
      step();
      if (dut_i_resp) i_read = 1'b0;
      if (dut_d_resp) begin d_read = 1'b0; d_write = 1'b0; end
    end
    rst = 1'b0; l2_resp = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
